tile_blitter: RTL and testbench
===============================

// Module: tile_blitter
// PURPOSE
//  Parametrised successor tile drawer: copies a TILE_W x TILE_H block of 24-bit pixels from pixel ROM to the VGA write bus.
//  - Placement at any (origin_x, origin_y).
//  - Optional horizontal mirror and colour-key transparency.
//  - Clipping at the screen edge.
//  - Pipelined ROM reads: one pixel per clock, fixed ROM latency.
//  - Shares the ROM address bus and VGA bus with other drawers; all shared outputs are tri-stated whenever active=0.
// PARAMETERS
//  TILE_W       120  tile width in pixels (>=1)
//  TILE_H       160  tile height in pixels (>=1)
//  SCREEN_W     160  screen width; pixels with x >= SCREEN_W are clipped
//  SCREEN_H     120  screen height; pixels with y >= SCREEN_H are clipped
//  COORD_W      8    width of x/y coordinates
//  ADDR_W       16   ROM address width
//  RGB_W        24   pixel colour width
//  ROM_LATENCY  2    cycles from rom_address_bus change to matching rom_data (>=1)
// PORTS
//  clk              in   1        system clock, rising edge
//  resetn           in   1        synchronous active-low reset
//  start            in   1        request a blit; sampled only in IDLE
//  base_addr        in   ADDR_W   ROM address of tile pixel (0,0); latched at start
//  origin_x         in   COORD_W  screen x of tile column 0; latched at start
//  origin_y         in   COORD_W  screen y of tile row 0; latched at start
//  flip_x           in   1        1 = mirror horizontally; latched at start
//  key_en           in   1        1 = enable colour-key transparency; latched at start
//  key_rgb          in   RGB_W    transparent colour; latched at start
//  rom_data         in   RGB_W    ROM read data
//  rom_address_bus  out  ADDR_W   ROM read address; Z when !active
//  vga_x_out_bus    out  COORD_W  pixel x; Z when !active
//  vga_y_out_bus    out  COORD_W  pixel y; Z when !active
//  vga_RGB_out_bus  out  RGB_W    pixel colour; Z when !active
//  vga_draw_enable_bus out 1      write strobe, one pixel per high cycle; Z when !active
//  active           out  1        block owns the shared buses (RUN, DRAIN, DONE)
//  done             out  1        one-cycle pulse at end of blit
// BEHAVIOUR
//  - Reset (resetn=0 at an edge): state IDLE. All counters, internal address and internal pipeline regs 0. Write strobe 0. active=0, done=0, so all buses Z.
//    Reset mid-blit aborts at once: no further writes, no done pulse.
//  - FSM:
//    - IDLE: if start, latch all inputs, clear col/row, go to RUN.
//    - RUN: lasts exactly TILE_W*TILE_H cycles, one ROM address per cycle. Go to DRAIN after the last address.
//    - DRAIN: lasts ROM_LATENCY+1 cycles, flushes the pipeline, then go to DONE.
//    - DONE: done=1 for 1 cycle, then IDLE.
//    - start is ignored outside IDLE. start held high re-triggers from IDLE on the cycle after DONE.
//  - Scan order: row-major; col 0..TILE_W-1 within row, then row+1.
//    ROM index = row*TILE_W + c, with c = flip_x ? TILE_W-1-col : col.
//    rom_address_bus = base_addr + index, modulo 2^ADDR_W. Built incrementally from a row-base register; no multiplier.
//  - Pipeline: (col, row) is carried through a ROM_LATENCY-deep delay line with a valid bit. rom_data is sampled ROM_LATENCY cycles after its address was driven.
//    The write strobe, x, y and RGB are registered one cycle after sampling.
//  - Address for pixel k (k=0 first) is driven in RUN cycle k. Its write slot is k+ROM_LATENCY+1 cycles later.
//  - Screen coordinates: x = origin_x + col, y = origin_y + row, computed COORD_W+1 bits wide.
//  - Write suppression: the write strobe is 0 in the slot if any of these holds:
//    - x >= SCREEN_W or y >= SCREEN_H (clip; the carry bit counts as overflow);
//    - key_en && rom_data == key_rgb.
//    On a suppressed slot, x/y/RGB may still update; their values are don't-care.
//  - Outside valid slots the write strobe is 0. The strobe is never high in IDLE or DONE.
//  - Latched inputs are stable for the whole blit; changing input pins mid-blit has no effect.
//  - Total blit length: start edge to done high = 1 + TILE_W*TILE_H + ROM_LATENCY + 1 cycles.
// TESTING
//  - TILE_W=4, TILE_H=2, LAT=2, base=0x0100, origin (10,20), ROM[a]=a:
//    -> addrs 0x0100..0x0107 on consecutive cycles; 8 writes (10..13,20),(10..13,21) with RGB=addr; done pulses once.
//  - Same, flip_x=1 -> row 0 writes x=10..13 with RGB 0x0103,0x0102,0x0101,0x0100.
//  - key_en=1, key_rgb=0x000102 -> exactly 7 write strobes; no write at (12,20).
//  - origin (158,119), 4x2 tile -> only (158,119),(159,119) written; no wrap to x=0 or y=0.
//  - resetn=0 during RUN after 3 addresses -> next cycle: IDLE, all buses Z, no done; a fresh start afterwards completes normally.
//  - start held high across two blits; start pulsed during RUN -> exactly one blit per IDLE entry; the pulse during RUN is ignored.
//    Repeat with ROM_LATENCY=1 and 3 to confirm write timing shifts accordingly.

Source files
------------

// File: rtl/tile_blitter.sv
// Tile blitter: streams a TILE_W x TILE_H block of pixels from ROM onto the shared VGA
// write bus with optional mirror, colour key and screen-edge clipping.
module tile_blitter #(
  parameter int unsigned TILE_W      = 120,
  parameter int unsigned TILE_H      = 160,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter int unsigned COORD_W     = 8,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned RGB_W       = 24,
  parameter int unsigned ROM_LATENCY = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [COORD_W-1:0] origin_x,
  input  logic [COORD_W-1:0] origin_y,
  input  logic               flip_x,
  input  logic               key_en,
  input  logic [RGB_W-1:0]   key_rgb,
  input  logic [RGB_W-1:0]   rom_data,
  output logic [ADDR_W-1:0]  rom_address_bus,
  output logic [COORD_W-1:0] vga_x_out_bus,
  output logic [COORD_W-1:0] vga_y_out_bus,
  output logic [RGB_W-1:0]   vga_RGB_out_bus,
  output logic               vga_draw_enable_bus,
  output logic               active,
  output logic               done
);

  localparam int unsigned COL_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int unsigned ROW_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int unsigned DR_W  = $clog2(ROM_LATENCY + 2);
  localparam int unsigned XY_W  = COORD_W + 1;

  localparam logic [ADDR_W-1:0] FLIP_OFS = ADDR_W'(TILE_W - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(TILE_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [ADDR_W-1:0]  r_row_base;
  logic [ADDR_W-1:0]  r_addr;
  logic [DR_W-1:0]    r_drain_cnt;

  logic               r_flip;
  logic               r_key_en;
  logic [RGB_W-1:0]   r_key_rgb;
  logic [COORD_W-1:0] r_origin_x;
  logic [COORD_W-1:0] r_origin_y;

  logic [ROM_LATENCY-1:0] r_pv;
  logic [COL_W-1:0]       r_pcol [ROM_LATENCY];
  logic [ROW_W-1:0]       r_prow [ROM_LATENCY];

  logic               r_we;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [RGB_W-1:0]   r_rgb;
  logic               r_active;
  logic               r_done;

  logic               w_last_col;
  logic               w_last_pix;
  logic               w_drain_end;
  logic [XY_W-1:0]    w_x_full;
  logic [XY_W-1:0]    w_y_full;
  logic               w_clip;
  logic               w_keyed;
  logic               w_we_next;

  assign w_last_col  = (r_col == COL_W'(TILE_W - 1));
  assign w_last_pix  = w_last_col && (r_row == ROW_W'(TILE_H - 1));
  assign w_drain_end = (r_drain_cnt == DR_W'(ROM_LATENCY));

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)       w_state_next = S_RUN;
      S_RUN:   if (w_last_pix)  w_state_next = S_DRAIN;
      S_DRAIN: if (w_drain_end) w_state_next = S_DONE;
      S_DONE:                   w_state_next = S_IDLE;
      default:                  w_state_next = S_IDLE;
    endcase
  end

  // Bus ownership and completion pulse track the upcoming state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_active <= (w_state_next != S_IDLE);
      r_done   <= (w_state_next == S_DONE);
    end
  end

  // Blit parameters captured at start
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_flip     <= 1'b0;
      r_key_en   <= 1'b0;
      r_key_rgb  <= '0;
      r_origin_x <= '0;
      r_origin_y <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_flip     <= flip_x;
      r_key_en   <= key_en;
      r_key_rgb  <= key_rgb;
      r_origin_x <= origin_x;
      r_origin_y <= origin_y;
    end
  end

  // Scan counters and incremental ROM address (row base + column offset, no multiply)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_col       <= '0;
      r_row       <= '0;
      r_row_base  <= '0;
      r_addr      <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + DR_W'(1) : '0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= base_addr;
            r_addr     <= base_addr + (flip_x ? FLIP_OFS : ADDR_W'(0));
          end
        end
        S_RUN: begin
          if (w_last_col) begin
            r_col      <= '0;
            r_row      <= r_row + ROW_W'(1);
            r_row_base <= r_row_base + ROW_STEP;
            r_addr     <= r_row_base + ROW_STEP + (r_flip ? FLIP_OFS : ADDR_W'(0));
          end else begin
            r_col  <= r_col + COL_W'(1);
            r_addr <= r_flip ? (r_addr - ADDR_W'(1)) : (r_addr + ADDR_W'(1));
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Coordinate delay line aligned with ROM read latency
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pv <= '0;
      for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
        r_pcol[i] <= '0;
        r_prow[i] <= '0;
      end
    end else begin
      r_pv[0]   <= (r_state == S_RUN);
      r_pcol[0] <= r_col;
      r_prow[0] <= r_row;
      for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pcol[i] <= r_pcol[i-1];
        r_prow[i] <= r_prow[i-1];
      end
    end
  end

  // Screen position carries one extra bit so wrap-around counts as off-screen
  assign w_x_full  = XY_W'(r_origin_x) + XY_W'(r_pcol[ROM_LATENCY-1]);
  assign w_y_full  = XY_W'(r_origin_y) + XY_W'(r_prow[ROM_LATENCY-1]);
  assign w_clip    = (w_x_full >= XY_W'(SCREEN_W)) || (w_y_full >= XY_W'(SCREEN_H));
  assign w_keyed   = r_key_en && (rom_data == r_key_rgb);
  assign w_we_next = r_pv[ROM_LATENCY-1] && !w_clip && !w_keyed;

  // Registered VGA write stage
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_we  <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
      r_rgb <= '0;
    end else begin
      r_we  <= w_we_next;
      r_x   <= w_x_full[COORD_W-1:0];
      r_y   <= w_y_full[COORD_W-1:0];
      r_rgb <= rom_data;
    end
  end

  // Shared buses released whenever another drawer may own them
  assign rom_address_bus     = r_active ? r_addr : {ADDR_W{1'bz}};
  assign vga_x_out_bus       = r_active ? r_x    : {COORD_W{1'bz}};
  assign vga_y_out_bus       = r_active ? r_y    : {COORD_W{1'bz}};
  assign vga_RGB_out_bus     = r_active ? r_rgb  : {RGB_W{1'bz}};
  assign vga_draw_enable_bus = r_active ? r_we   : 1'bz;
  assign active              = r_active;
  assign done                = r_done;

endmodule

// File: tb/tb_tile_blitter.sv
// Scoreboard bench for tile_blitter: 4x2 tile, ROM[a]=a, extra instances at ROM latency 1 and 3.
module tb_tile_blitter;

  localparam int unsigned TW   = 4;
  localparam int unsigned TH   = 2;
  localparam int unsigned NPIX = TW * TH;
  localparam int unsigned LAT  = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        lane_start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0]  origin_x = '0;
  logic [7:0]  origin_y = '0;
  logic        flip_x = 1'b0;
  logic        key_en = 1'b0;
  logic [23:0] key_rgb = '0;
  logic [23:0] rom_data;

  wire [15:0] rom_address_bus;
  wire [7:0]  vga_x_out_bus;
  wire [7:0]  vga_y_out_bus;
  wire [23:0] vga_RGB_out_bus;
  wire        vga_draw_enable_bus;
  wire        active;
  wire        done;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int unsigned writes_seen = 0;
  int unsigned dones_seen = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [23:0] rgb;
  } wr_t;

  wr_t         exp_wr[$];
  int unsigned exp_done[$];
  wr_t         mon_e;
  int unsigned mon_d;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tile_blitter #(
    .TILE_W(TW), .TILE_H(TH), .SCREEN_W(160), .SCREEN_H(120),
    .COORD_W(8), .ADDR_W(16), .RGB_W(24), .ROM_LATENCY(LAT)
  ) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .origin_x(origin_x), .origin_y(origin_y), .flip_x(flip_x), .key_en(key_en),
    .key_rgb(key_rgb), .rom_data(rom_data), .rom_address_bus(rom_address_bus),
    .vga_x_out_bus(vga_x_out_bus), .vga_y_out_bus(vga_y_out_bus),
    .vga_RGB_out_bus(vga_RGB_out_bus), .vga_draw_enable_bus(vga_draw_enable_bus),
    .active(active), .done(done)
  );

  // ROM model: ROM[a] = a, data appears LAT cycles after the address
  logic [23:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= {8'h00, rom_address_bus};
    for (int unsigned i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[LAT-1];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: compare every write strobe and done pulse against the scoreboard
  always @(negedge clk) begin
    if (active === 1'b1 && vga_draw_enable_bus === 1'b1) begin
      writes_seen++;
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got strobe x=%0d y=%0d at cycle %0d, required none",
                 vga_x_out_bus, vga_y_out_bus, cyc);
      end else begin
        mon_e = exp_wr.pop_front();
        check("write_cycle", cyc, mon_e.cyc);
        check("write_x", vga_x_out_bus, mon_e.x);
        check("write_y", vga_y_out_bus, mon_e.y);
        check("write_rgb", vga_RGB_out_bus, mon_e.rgb);
      end
    end
    if (done === 1'b1) begin
      dones_seen++;
      if (exp_done.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done pulse at cycle %0d, required none", cyc);
      end else begin
        mon_d = exp_done.pop_front();
        check("done_cycle", cyc, mon_d);
      end
    end
  end

  // Expected writes for a blit whose start is sampled at the end of cycle s
  task automatic push_blit(input logic [15:0] b, input logic [7:0] ox, input logic [7:0] oy,
                           input logic fl, input logic ke, input logic [23:0] kr,
                           input int unsigned s);
    for (int unsigned r = 0; r < TH; r++) begin
      for (int unsigned c = 0; c < TW; c++) begin
        int unsigned cc;
        int unsigned xs;
        int unsigned ys;
        logic [15:0] a;
        wr_t w;
        cc = fl ? (TW - 1 - c) : c;
        a  = 16'(int'(b) + r * TW + cc);
        xs = ox + c;
        ys = oy + r;
        if (xs >= 160 || ys >= 120) continue;
        if (ke && ({8'h00, a} == kr)) continue;
        w.cyc = 32'(s + r * TW + c + LAT + 2);
        w.x   = 8'(xs);
        w.y   = 8'(ys);
        w.rgb = {8'h00, a};
        exp_wr.push_back(w);
      end
    end
    exp_done.push_back(s + NPIX + LAT + 2);
  endtask

  // Start one blit, scramble the input pins mid-blit, wait for it to finish
  task automatic run_blit(input logic [15:0] b, input logic [7:0] ox, input logic [7:0] oy,
                          input logic fl, input logic ke, input logic [23:0] kr,
                          output int unsigned nw);
    int unsigned s;
    int unsigned w0;
    @(posedge clk); #2;
    base_addr = b; origin_x = ox; origin_y = oy; flip_x = fl; key_en = ke; key_rgb = kr;
    start = 1'b1;
    s  = cyc;
    w0 = writes_seen;
    push_blit(b, ox, oy, fl, ke, kr, s);
    @(posedge clk); #2;
    start = 1'b0;
    base_addr = 16'hBEEF; origin_x = 8'd0; origin_y = 8'd0;
    flip_x = ~fl; key_en = ~ke; key_rgb = 24'h000000;
    repeat (NPIX + LAT + 4) @(posedge clk);
    #2;
    nw = writes_seen - w0;
    check("pending_writes", exp_wr.size(), 0);
    check("pending_done", exp_done.size(), 0);
  endtask

  // Latency variants: same 4x2 tile at (10,20), base 0x0100
  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int unsigned LL = (g == 0) ? 1 : 3;
    wire [15:0] l_addr;
    wire [7:0]  l_x;
    wire [7:0]  l_y;
    wire [23:0] l_rgb;
    wire        l_we;
    wire        l_active;
    wire        l_done;
    logic [23:0] l_rom [LL];
    logic [23:0] l_rom_data;
    int unsigned first_wr = 0;
    int unsigned done_at = 0;
    int unsigned nwr = 0;

    always @(posedge clk) begin
      l_rom[0] <= {8'h00, l_addr};
      for (int unsigned i = 1; i < LL; i++) l_rom[i] <= l_rom[i-1];
    end
    assign l_rom_data = l_rom[LL-1];

    tile_blitter #(
      .TILE_W(TW), .TILE_H(TH), .SCREEN_W(160), .SCREEN_H(120),
      .COORD_W(8), .ADDR_W(16), .RGB_W(24), .ROM_LATENCY(LL)
    ) u_lane (
      .clk(clk), .resetn(resetn), .start(lane_start), .base_addr(16'h0100),
      .origin_x(8'd10), .origin_y(8'd20), .flip_x(1'b0), .key_en(1'b0),
      .key_rgb(24'h000000), .rom_data(l_rom_data), .rom_address_bus(l_addr),
      .vga_x_out_bus(l_x), .vga_y_out_bus(l_y), .vga_RGB_out_bus(l_rgb),
      .vga_draw_enable_bus(l_we), .active(l_active), .done(l_done)
    );

    always @(negedge clk) begin
      if (l_active === 1'b1 && l_we === 1'b1) begin
        if (nwr == 0) first_wr <= cyc;
        nwr <= nwr + 1;
      end
      if (l_done === 1'b1) done_at <= cyc;
    end
  end

  initial begin
    int unsigned nw;
    int unsigned s;
    int unsigned w0;
    int unsigned d0;

    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    check("reset_active", active, 0);
    check("reset_done", done, 0);
    check("reset_lane1_active", g_lane[0].l_active, 0);
    check("reset_lane3_active", g_lane[1].l_active, 0);

    // Latency 1 and 3: write timing shifts with the ROM latency
    @(posedge clk); #2;
    lane_start = 1'b1;
    s = cyc;
    @(posedge clk); #2;
    lane_start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    check("lat1_first_write", g_lane[0].first_wr, s + 3);
    check("lat1_done", g_lane[0].done_at, s + 11);
    check("lat1_writes", g_lane[0].nwr, 8);
    check("lat3_first_write", g_lane[1].first_wr, s + 5);
    check("lat3_done", g_lane[1].done_at, s + 13);
    check("lat3_writes", g_lane[1].nwr, 8);

    // Plain blit
    run_blit(16'h0100, 8'd10, 8'd20, 1'b0, 1'b0, 24'h0, nw);
    check("plain_writes", nw, 8);

    // Mirrored
    run_blit(16'h0100, 8'd10, 8'd20, 1'b1, 1'b0, 24'h0, nw);
    check("flip_writes", nw, 8);

    // Colour key hides (12,20)
    run_blit(16'h0100, 8'd10, 8'd20, 1'b0, 1'b1, 24'h000102, nw);
    check("key_writes", nw, 7);

    // Bottom-right corner clip
    run_blit(16'h0100, 8'd158, 8'd119, 1'b0, 1'b0, 24'h0, nw);
    check("clip_writes", nw, 2);

    // Address wraps modulo 2^16
    run_blit(16'hFFFE, 8'd0, 8'd0, 1'b0, 1'b0, 24'h0, nw);
    check("wrap_writes", nw, 8);

    // Reset after three addresses: abort without writes or done
    @(posedge clk); #2;
    base_addr = 16'h0100; origin_x = 8'd10; origin_y = 8'd20; flip_x = 1'b0; key_en = 1'b0;
    start = 1'b1;
    w0 = writes_seen;
    d0 = dones_seen;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    resetn = 1'b0;
    @(posedge clk); #2;
    resetn = 1'b1;
    @(negedge clk);
    check("abort_active", active, 0);
    check("abort_done", done, 0);
    repeat (NPIX + LAT + 4) @(posedge clk);
    #2;
    check("abort_writes", writes_seen - w0, 0);
    check("abort_dones", dones_seen - d0, 0);

    run_blit(16'h0100, 8'd10, 8'd20, 1'b0, 1'b0, 24'h0, nw);
    check("after_abort_writes", nw, 8);

    // start held across two blits, then a pulse during RUN is ignored
    @(posedge clk); #2;
    base_addr = 16'h0200; origin_x = 8'd30; origin_y = 8'd40; flip_x = 1'b0; key_en = 1'b0;
    start = 1'b1;
    s  = cyc;
    w0 = writes_seen;
    d0 = dones_seen;
    push_blit(16'h0200, 8'd30, 8'd40, 1'b0, 1'b0, 24'h0, s);
    push_blit(16'h0200, 8'd30, 8'd40, 1'b0, 1'b0, 24'h0, s + NPIX + LAT + 3);
    repeat (NPIX + LAT + 4) @(posedge clk);
    #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (NPIX + LAT + 6) @(posedge clk);
    #2;
    check("held_dones", dones_seen - d0, 2);
    check("held_writes", writes_seen - w0, 16);
    check("held_pending_writes", exp_wr.size(), 0);
    check("held_pending_done", exp_done.size(), 0);
    check("held_idle_active", active, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
